// File: rtl/div_clk_monitor_if.sv
// Signal bundle between a divider-under-test driver (master) and the divided-clock monitor (slave).
interface div_clk_monitor_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             div_clk_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             ratio_err;
    logic             stuck;
    logic [CNT_W-1:0] err_count;

    modport master (
        output en, div_clk_in,
        input  period, high_time, meas_valid, locked, ratio_err, stuck, err_count
    );

    modport slave (
        input  en, div_clk_in,
        output period, high_time, meas_valid, locked, ratio_err, stuck, err_count
    );
endinterface

// File: rtl/div_clk_monitor.sv
// Divided-clock checker: measures period and high time of div_clk_in in clk cycles,
// tracks lock against EXP_DIV, flags ratio errors and a stuck (edge-less) input.
module div_clk_monitor #(
    parameter int CNT_W    = 8,
    parameter int EXP_DIV  = 3,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    div_clk_monitor_if.slave mon
);
    localparam logic [CNT_W-1:0] MAXC   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] EXP_C  = CNT_W'(EXP_DIV);
    localparam logic [3:0]       LOCK_C = 4'(LOCK_CNT);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state_q, state_d;
    logic             s0_q, s1_q;
    logic             rise;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic [3:0]       good_q, good_d, good_inc;
    logic             mv_q, mv_d;
    logic             lock_q, lock_d;
    logic             rerr_q, rerr_d;
    logic             stuck_q, stuck_d;

    assign rise     = s0_q & ~s1_q;
    assign good_inc = (good_q >= LOCK_C) ? LOCK_C : good_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        errc_d    = errc_q;
        good_d    = good_q;
        lock_d    = lock_q;
        stuck_d   = stuck_q;
        mv_d      = 1'b0;
        rerr_d    = 1'b0;

        if (!mon.en) begin
            state_d = IDLE;
            lock_d  = 1'b0;
            good_d  = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // First edge only arms; nothing to report yet.
                    if (rise) begin
                        per_cnt_d = ONE;
                        hi_cnt_d  = ONE;
                        stuck_d   = 1'b0;
                        state_d   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d  = per_cnt_q;
                        high_d    = hi_cnt_q;
                        mv_d      = 1'b1;
                        per_cnt_d = ONE;
                        hi_cnt_d  = ONE;
                        if (per_cnt_q == EXP_C) begin
                            good_d = good_inc;
                            if (good_inc == LOCK_C) lock_d = 1'b1;
                        end else begin
                            rerr_d = 1'b1;
                            lock_d = 1'b0;
                            good_d = 4'd0;
                            if (errc_q != MAXC) errc_d = errc_q + ONE;
                        end
                    end else if (per_cnt_q == MAXC) begin
                        stuck_d = 1'b1;
                        lock_d  = 1'b0;
                        good_d  = 4'd0;
                        state_d = IDLE;
                    end else begin
                        // per_cnt is below MAXC here, so this increment cannot wrap.
                        per_cnt_d = per_cnt_q + ONE;
                        if (s0_q && hi_cnt_q != MAXC) hi_cnt_d = hi_cnt_q + ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            s0_q      <= 1'b0;
            s1_q      <= 1'b0;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            errc_q    <= '0;
            good_q    <= 4'd0;
            mv_q      <= 1'b0;
            lock_q    <= 1'b0;
            rerr_q    <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            s0_q      <= mon.div_clk_in;
            s1_q      <= s0_q;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            errc_q    <= errc_d;
            good_q    <= good_d;
            mv_q      <= mv_d;
            lock_q    <= lock_d;
            rerr_q    <= rerr_d;
            stuck_q   <= stuck_d;
        end
    end

    assign mon.period     = period_q;
    assign mon.high_time  = high_q;
    assign mon.meas_valid = mv_q;
    assign mon.locked     = lock_q;
    assign mon.ratio_err  = rerr_q;
    assign mon.stuck      = stuck_q;
    assign mon.err_count  = errc_q;
endmodule

// File: tb/tb_div_clk_monitor.sv
// Bench for div_clk_monitor: table-driven pattern vectors, directed corner sequences,
// and randomized traffic compared every cycle against a timestamp-based reference model.
module tb_div_clk_monitor;
    localparam int CNT_W    = 8;
    localparam int EXP_DIV  = 3;
    localparam int LOCK_CNT = 4;
    localparam int MAXC     = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_clk_monitor_if #(.CNT_W(CNT_W)) ifc ();

    div_clk_monitor #(.CNT_W(CNT_W), .EXP_DIV(EXP_DIV), .LOCK_CNT(LOCK_CNT)) dut (
        .clk (clk),
        .rst (rst_n),
        .mon (ifc)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic d);
        rst_n          = r;
        ifc.en         = e;
        ifc.div_clk_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic run_pattern(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            repeat (hi) step(1'b1, 1'b1, 1'b1);
            repeat (lo) step(1'b1, 1'b1, 1'b0);
        end
    endtask

    // Reference model: remembers when the measurement was armed and the sampled
    // level history, and derives period / high time from timestamps.
    bit          s0_at [0:4095];
    int          edge_n = 0;
    int          t_arm  = 0;
    bit          armed  = 1'b0;
    bit          m_s0 = 1'b0, m_s1 = 1'b0, m_rise;
    int          m_p, m_h, m_good = 0;
    logic [7:0]  m_period = '0, m_high = '0, m_errc = '0;
    logic        m_mv = 1'b0, m_lock = 1'b0, m_rerr = 1'b0, m_stuck = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            m_rise = m_s0 & ~m_s1;
            s0_at[edge_n % 4096] = m_s0;
            m_mv   = 1'b0;
            m_rerr = 1'b0;
            if (!rst_n) begin
                m_period = '0; m_high = '0; m_errc = '0;
                m_lock = 1'b0; m_stuck = 1'b0; m_good = 0;
                armed = 1'b0; m_s0 = 1'b0; m_s1 = 1'b0;
            end else begin
                if (!ifc.en) begin
                    armed = 1'b0; m_lock = 1'b0; m_good = 0;
                end else if (!armed) begin
                    if (m_rise) begin
                        armed = 1'b1; t_arm = edge_n; m_stuck = 1'b0;
                    end
                end else if (m_rise) begin
                    m_p = edge_n - t_arm;
                    m_h = 0;
                    for (int k = t_arm; k < edge_n; k++) m_h += int'(s0_at[k % 4096]);
                    m_period = 8'((m_p > MAXC) ? MAXC : m_p);
                    m_high   = 8'((m_h > MAXC) ? MAXC : m_h);
                    m_mv     = 1'b1;
                    if (m_p == EXP_DIV) begin
                        if (m_good < LOCK_CNT) m_good++;
                        if (m_good == LOCK_CNT) m_lock = 1'b1;
                    end else begin
                        m_rerr = 1'b1; m_lock = 1'b0; m_good = 0;
                        if (m_errc != 8'(MAXC)) m_errc = m_errc + 8'd1;
                    end
                    t_arm = edge_n;
                end else if (edge_n - t_arm == MAXC) begin
                    m_stuck = 1'b1; m_lock = 1'b0; m_good = 0; armed = 1'b0;
                end
                m_s1 = m_s0;
                m_s0 = ifc.div_clk_in;
            end
            edge_n++;
        end
    end

    logic [27:0] act_v, exp_v;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                act_v = {ifc.period, ifc.high_time, ifc.meas_valid, ifc.locked,
                         ifc.ratio_err, ifc.stuck, ifc.err_count};
                exp_v = {m_period, m_high, m_mv, m_lock, m_rerr, m_stuck, m_errc};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL model_cmp edge=%0d got=%h want=%h", edge_n, act_v, exp_v);
                end
            end
        end
    end

    typedef struct {
        int         hi;
        int         lo;
        int         n;
        logic [7:0] period;
        logic [7:0] high;
        logic       locked;
        logic [7:0] errc;
    } vec_t;

    vec_t vt [5];
    int   mv_seen;
    int   hi_r, lo_r, sel;

    initial begin
        vt[0] = '{hi:1, lo:2, n:6, period:8'd3, high:8'd1, locked:1'b1, errc:8'd0};
        vt[1] = '{hi:2, lo:1, n:6, period:8'd3, high:8'd2, locked:1'b1, errc:8'd0};
        vt[2] = '{hi:2, lo:2, n:2, period:8'd4, high:8'd2, locked:1'b0, errc:8'd1};
        vt[3] = '{hi:1, lo:2, n:5, period:8'd3, high:8'd1, locked:1'b1, errc:8'd2};
        vt[4] = '{hi:3, lo:2, n:2, period:8'd5, high:8'd3, locked:1'b0, errc:8'd3};

        // Reset held with the input toggling.
        step(1'b0, 1'b1, 1'b1);
        chk_on = 1'b1;
        chk("reset_outs0", 32'({ifc.period, ifc.high_time, ifc.meas_valid, ifc.locked,
                                ifc.ratio_err, ifc.stuck, ifc.err_count}), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("reset_outs2", 32'({ifc.period, ifc.high_time, ifc.meas_valid, ifc.locked,
                                ifc.ratio_err, ifc.stuck, ifc.err_count}), 32'd0);
        step(1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_pattern(vt[i].hi, vt[i].lo, vt[i].n);
            chk($sformatf("vec%0d_period", i), 32'(ifc.period), 32'(vt[i].period));
            chk($sformatf("vec%0d_high", i), 32'(ifc.high_time), 32'(vt[i].high));
            chk($sformatf("vec%0d_locked", i), 32'(ifc.locked), 32'(vt[i].locked));
            chk($sformatf("vec%0d_errc", i), 32'(ifc.err_count), 32'(vt[i].errc));
        end

        // Input held low after an arming rise: timeout, no measurement.
        mv_seen = 0;
        repeat (300) begin
            step(1'b1, 1'b1, 1'b0);
            if (ifc.meas_valid === 1'b1) mv_seen++;
        end
        chk("stuck_set", 32'(ifc.stuck), 32'd1);
        chk("stuck_locked", 32'(ifc.locked), 32'd0);
        chk("stuck_no_mv", 32'(mv_seen), 32'd0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("stuck_clear", 32'(ifc.stuck), 32'd0);
        chk("rearm_no_mv", 32'(ifc.meas_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("resume_mv", 32'(ifc.meas_valid), 32'd1);
        chk("resume_period", 32'(ifc.period), 32'd3);
        step(1'b1, 1'b1, 1'b0);

        // Drop enable while locked.
        run_pattern(1, 2, 5);
        chk("pre_drop_locked", 32'(ifc.locked), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("drop_locked", 32'(ifc.locked), 32'd0);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        chk("drop_period_hold", 32'(ifc.period), 32'd3);
        run_pattern(1, 2, 4);
        chk("relock_early", 32'(ifc.locked), 32'd0);
        run_pattern(1, 2, 1);
        chk("relock", 32'(ifc.locked), 32'd1);

        // Reset in the middle of a period.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("midrst_outs", 32'({ifc.period, ifc.high_time, ifc.meas_valid, ifc.locked,
                                ifc.ratio_err, ifc.stuck, ifc.err_count}), 32'd0);
        step(1'b1, 1'b1, 1'b0);

        // Many bad periods: error counter saturates.
        run_pattern(1, 1, 300);
        chk("sat_errc", 32'(ifc.err_count), 32'd255);
        chk("sat_period", 32'(ifc.period), 32'd2);

        // Randomized traffic, checked by the model every cycle.
        for (int it = 0; it < 150; it++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            end else if (sel <= 2) begin
                repeat ($urandom_range(1, 6)) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    hi_r = int'($urandom_range(1, 2));
                    lo_r = 3 - hi_r;
                end else begin
                    hi_r = int'($urandom_range(1, 5));
                    lo_r = int'($urandom_range(1, 5));
                end
                run_pattern(hi_r, lo_r, int'($urandom_range(1, 4)));
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
